// File: rtl/p2s_tx_scheduler.sv
`timescale 1ns/1ps
// Round-robin two-source transmit scheduler: accepts one word in IDLE,
// shifts it out MSB-first, then holds the line idle for GAP cycles.
module p2s_tx_scheduler #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             first_bit,
  output logic             grant_id,
  output logic             busy
);

  localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_grant;
  logic             grant_q;
  logic             win1;
  logic             accept;

  // Requester 1 wins when it is the only one valid, or on a tie when 0 went last.
  assign win1 = req1_valid && (!req0_valid || !last_grant);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !win1;
          req1_ready = win1;
        end
        accept = req0_valid || req1_valid;
        if (accept) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == LAST_BIT) state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (cnt == LAST_GAP) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: shreg is a plain register, not a memory, so it is cleared on reset like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg      <= win1 ? req1_data : req0_data;
            grant_q    <= win1;
            last_grant <= win1;
            cnt        <= '0;
          end
        end
        ST_SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= (cnt == LAST_BIT) ? '0 : cnt + 1'b1;
        end
        ST_GAP: begin
          cnt <= (cnt == LAST_GAP) ? '0 : cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset clears the line without a clock.
  assign serial_valid = (state == ST_SHIFT);
  assign serial_out   = serial_valid && shreg[WIDTH-1];
  assign first_bit    = serial_valid && (cnt == '0);
  assign busy         = (state != ST_IDLE);
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_p2s_tx_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for p2s_tx_scheduler: one instance with GAP=1, one with GAP=0.
module tb_p2s_tx_scheduler;

  typedef struct packed {
    logic b;
    logic f;
    logic id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_req0_valid = 1'b0, a_req1_valid = 1'b0;
  logic [3:0] a_req0_data = '0, a_req1_data = '0;
  logic       a_req0_ready, a_req1_ready, a_serial_out, a_serial_valid;
  logic       a_first_bit, a_grant_id, a_busy;

  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [3:0] b_req0_data = '0, b_req1_data = '0;
  logic       b_req0_ready, b_req1_ready, b_serial_out, b_serial_valid;
  logic       b_first_bit, b_grant_id, b_busy;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  p2s_tx_scheduler #(.WIDTH(4), .GAP(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .serial_out(a_serial_out), .serial_valid(a_serial_valid), .first_bit(a_first_bit),
    .grant_id(a_grant_id), .busy(a_busy)
  );

  p2s_tx_scheduler #(.WIDTH(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .serial_out(b_serial_out), .serial_valid(b_serial_valid), .first_bit(b_first_bit),
    .grant_id(b_grant_id), .busy(b_busy)
  );

  // Expected bit stream for a word, MSB first, with its framing and source id.
  task automatic push_word(input logic [3:0] w, input logic id, input bit to_b);
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      e.b  = w[i];
      e.f  = (i == 3);
      e.id = id;
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (a_serial_valid) begin
        if (q_a.size() == 0) begin
          failures++;
          $display("FAIL a_stream: unexpected bit %b with no word in flight", a_serial_out);
        end else begin
          ea = q_a.pop_front();
          if ({a_serial_out, a_first_bit, a_grant_id} !== {ea.b, ea.f, ea.id}) begin
            failures++;
            $display("FAIL a_stream: out/first/id=%b%b%b expected %b%b%b",
                     a_serial_out, a_first_bit, a_grant_id, ea.b, ea.f, ea.id);
          end
        end
      end else if ({a_serial_out, a_first_bit} !== 2'b00) begin
        failures++;
        $display("FAIL a_idle_line: out/first=%b%b expected 00", a_serial_out, a_first_bit);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (b_serial_valid) begin
        if (q_b.size() == 0) begin
          failures++;
          $display("FAIL b_stream: unexpected bit %b with no word in flight", b_serial_out);
        end else begin
          eb = q_b.pop_front();
          if ({b_serial_out, b_first_bit, b_grant_id} !== {eb.b, eb.f, eb.id}) begin
            failures++;
            $display("FAIL b_stream: out/first/id=%b%b%b expected %b%b%b",
                     b_serial_out, b_first_bit, b_grant_id, eb.b, eb.f, eb.id);
          end
        end
      end else if ({b_serial_out, b_first_bit} !== 2'b00) begin
        failures++;
        $display("FAIL b_idle_line: out/first=%b%b expected 00", b_serial_out, b_first_bit);
      end
    end
  end

  // Bounded wait until both scoreboards drain and both FSMs are back in IDLE.
  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (q_a.size() == 0) && (q_b.size() == 0) && !a_busy && !b_busy;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: queues=%0d/%0d busy=%b%b expected 0/0 and 00",
               tag, q_a.size(), q_b.size(), a_busy, b_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req0_valid = 1'b1;
    a_req0_data  = 4'b1011;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_serial_out, a_serial_valid, a_first_bit, a_grant_id, a_busy, a_req0_ready, a_req1_ready}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {a_serial_out, a_serial_valid, a_first_bit, a_grant_id, a_busy, a_req0_ready, a_req1_ready});
    end
    rst = 1'b0;
    push_word(4'b1011, 1'b0, 0);
    #1;
    checks++;
    if (a_req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_ready: req0_ready=%b expected 1", a_req0_ready);
    end
    @(posedge clk);
    #1 a_req0_valid = 1'b0;
    wait_idle("reset");
  endtask

  task automatic test_tie();
    logic e0, e1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_req0_data = 4'hA;
    a_req1_data = 4'h5;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    push_word(4'hA, 1'b0, 0);
    push_word(4'h5, 1'b1, 0);
    push_word(4'hA, 1'b0, 0);
    push_word(4'h5, 1'b1, 0);
    for (int i = 0; i <= 18; i++) begin
      #1;
      e0 = (i % 12 == 0);
      e1 = (i % 12 == 6);
      checks++;
      if ({a_req0_ready, a_req1_ready} !== {e0, e1}) begin
        failures++;
        $display("FAIL tie_ready[%0d]: ready0/1=%b%b expected %b%b",
                 i, a_req0_ready, a_req1_ready, e0, e1);
      end
      @(posedge clk);
      if (i < 18) @(negedge clk);
    end
    #1;
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    wait_idle("tie");
  endtask

  task automatic test_back_to_back();
    b_req1_data  = 4'hC;
    b_req1_valid = 1'b1;
    push_word(4'hC, 1'b1, 1);
    push_word(4'hC, 1'b1, 1);
    push_word(4'hC, 1'b1, 1);
    for (int i = 0; i <= 10; i++) begin
      #1;
      checks++;
      if (b_req1_ready !== (i % 5 == 0)) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: req1_ready=%b expected %b", i, b_req1_ready, (i % 5 == 0));
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (b_serial_valid !== (i % 5 != 4)) begin
        failures++;
        $display("FAIL b2b_valid[%0d]: serial_valid=%b expected %b", i, b_serial_valid, (i % 5 != 4));
      end
    end
    b_req1_valid = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_stability();
    a_req0_data  = 4'hF;
    a_req0_valid = 1'b1;
    push_word(4'hF, 1'b0, 0);
    @(posedge clk);
    #1;
    a_req0_valid = 1'b0;
    a_req0_data  = 4'h0;
    wait_idle("stability");
  endtask

  task automatic test_reset_mid();
    a_req0_data  = 4'b1100;
    a_req0_valid = 1'b1;
    push_word(4'b1100, 1'b0, 0);
    @(posedge clk);
    #1 a_req0_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_serial_valid, a_serial_out, a_first_bit, a_busy, a_grant_id} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_outputs: valid/out/first/busy/id=%b expected 00000",
               {a_serial_valid, a_serial_out, a_first_bit, a_busy, a_grant_id});
    end
    q_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a_req0_data  = 4'hA;
    a_req1_data  = 4'h5;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    push_word(4'hA, 1'b0, 0);
    #1;
    checks++;
    if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_pointer: ready0/1=%b%b expected 10", a_req0_ready, a_req1_ready);
    end
    @(posedge clk);
    #1;
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    wait_idle("midreset");
  endtask

  task automatic test_single_idle();
    a_req1_data  = 4'h6;
    a_req1_valid = 1'b1;
    push_word(4'h6, 1'b1, 0);
    @(posedge clk);
    #1 a_req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (a_busy !== (i < 5)) begin
        failures++;
        $display("FAIL single_busy[%0d]: busy=%b expected %b", i, a_busy, (i < 5));
      end
    end
    wait_idle("single");
  endtask

  initial begin
    test_reset();
    test_tie();
    test_back_to_back();
    test_stability();
    test_reset_mid();
    test_single_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
